// File: rtl/pitch_track_hz.sv
// Median-of-3 filtered, stability-gated FFT bin to Hz converter; 1-cycle accept-to-valid latency.
// Single output register; input ready = !valid || downstream ready, so a stalled result blocks new input.
module pitch_track_hz #(
  parameter int W             = 16,
  parameter int HZ_PER_BIN_Q8 = 571,
  parameter int TOL           = 1,
  parameter int STABLE        = 4,
  parameter int MIN_BIN       = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pitch_input_data,
  input  logic         pitch_input_valid,
  output logic         pitch_input_ready,
  output logic [W-1:0] freq_output_data,
  output logic         freq_output_valid,
  input  logic         freq_output_ready
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int W2 = 2 * W;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);
  localparam logic [W-1:0]  TOL_C    = W'(TOL);
  localparam logic [W-1:0]  MIN_C    = W'(MIN_BIN);
  localparam logic [W2-1:0] HZ_C     = W2'(HZ_PER_BIN_Q8);
  localparam logic [W2-1:0] RND_C    = W2'(128);

  // Only two history taps are stored: after the shift the oldest sample is h1 and
  // the newest is the incoming bin, so a third register would never be read.
  logic [1:0]    fill, fill_n;
  logic [W-1:0]  h0, h1, h0_n, h1_n;
  logic [W-1:0]  cand, cand_n, rep, rep_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rep_vld, rep_vld_n;
  logic          accept, emit;
  logic [W-1:0]  med, diff;

  function automatic logic [W-1:0] med3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] lo, hi, mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (mid > lo) ? mid : lo;
  endfunction

  assign pitch_input_ready = !freq_output_valid || freq_output_ready;
  assign accept            = pitch_input_valid && pitch_input_ready;
  assign med               = med3(pitch_input_data, h0, h1);
  assign diff              = (med > cand) ? (med - cand) : (cand - med);

  always_comb begin
    fill_n    = fill;
    h0_n      = h0;
    h1_n      = h1;
    cand_n    = cand;
    cnt_n     = cnt;
    rep_n     = rep;
    rep_vld_n = rep_vld;
    emit      = 1'b0;
    if (accept) begin
      if (pitch_input_data < MIN_C) begin
        fill_n    = 2'd0;
        h0_n      = '0;
        h1_n      = '0;
        cand_n    = '0;
        cnt_n     = '0;
        rep_vld_n = 1'b0;
      end else begin
        h0_n   = pitch_input_data;
        h1_n   = h0;
        fill_n = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
        if (fill_n == 2'd3) begin
          // The candidate is the anchor: in-tolerance medians only bump the count.
          if (diff <= TOL_C && cnt != '0) begin
            cnt_n = (cnt == STABLE_C) ? cnt : cnt + CW'(1);
          end else begin
            cand_n = med;
            cnt_n  = CW'(1);
          end
          if (cnt_n == STABLE_C && (!rep_vld || cand_n != rep)) begin
            emit      = 1'b1;
            rep_n     = cand_n;
            rep_vld_n = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill              <= 2'd0;
      h0                <= '0;
      h1                <= '0;
      cand              <= '0;
      cnt               <= '0;
      rep               <= '0;
      rep_vld           <= 1'b0;
      freq_output_valid <= 1'b0;
      freq_output_data  <= '0;
    end else begin
      fill    <= fill_n;
      h0      <= h0_n;
      h1      <= h1_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      rep     <= rep_n;
      rep_vld <= rep_vld_n;
      if (emit) begin
        freq_output_valid <= 1'b1;
        freq_output_data  <= W'((({{W{1'b0}}, cand_n} * HZ_C) + RND_C) >> 8);
      end else if (freq_output_ready) begin
        freq_output_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pitch_track_hz.sv
// Scoreboard bench for pitch_track_hz: a list-based reference model pushes expected Hz values,
// a monitor pops them on each output handshake.
module tb_pitch_track_hz;

  logic        clk;
  logic        reset;
  logic [15:0] pitch_input_data;
  logic        pitch_input_valid;
  logic        pitch_input_ready;
  logic [15:0] freq_output_data;
  logic        freq_output_valid;
  logic        freq_output_ready;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  int          hist[$];
  int          m_cand, m_cnt, m_rep;
  bit          m_rep_v;

  pitch_track_hz #(
    .W(16), .HZ_PER_BIN_Q8(571), .TOL(1), .STABLE(4), .MIN_BIN(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pitch_input_data  (pitch_input_data),
    .pitch_input_valid (pitch_input_valid),
    .pitch_input_ready (pitch_input_ready),
    .freq_output_data  (freq_output_data),
    .freq_output_valid (freq_output_valid),
    .freq_output_ready (freq_output_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    m_cand  = 0;
    m_cnt   = 0;
    m_rep_v = 1'b0;
    m_rep   = 0;
  endfunction

  // Reference: keep the last three non-silent bins, sort them, take the middle one.
  function automatic void model_accept(input int k);
    int s[3];
    int t, med, d;
    if (k < 4) begin
      model_clear();
      return;
    end
    hist.push_front(k);
    if (hist.size() > 3) void'(hist.pop_back());
    if (hist.size() < 3) return;
    for (int i = 0; i < 3; i++) s[i] = hist[i];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    med = s[1];
    d = (med > m_cand) ? med - m_cand : m_cand - med;
    if (d <= 1 && m_cnt != 0) begin
      if (m_cnt < 4) m_cnt++;
    end else begin
      m_cand = med;
      m_cnt  = 1;
    end
    if (m_cnt == 4 && (!m_rep_v || m_cand != m_rep)) begin
      exp_q.push_back(16'((m_cand * 571 + 128) / 256));
      m_rep   = m_cand;
      m_rep_v = 1'b1;
    end
  endfunction

  task automatic step(input bit v, input int k, input bit r);
    @(negedge clk);
    pitch_input_valid = v;
    pitch_input_data  = k[15:0];
    freq_output_ready = r;
    #4;
    if (v && (exp_q.size() == 0 || r)) model_accept(k);
  endtask

  task automatic feed(input int k, input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b1, k, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pitch_input_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_valid", int'(freq_output_valid), 0);
    check("rst_data", int'(freq_output_data), 0);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor samples 2 ns before the rising edge, ahead of the driver's accept decision.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      check("in_ready", int'(pitch_input_ready), int'(exp_q.size() == 0 || freq_output_ready));
      if (exp_q.size() != 0) begin
        check("out_valid_pending", int'(freq_output_valid), 1);
        if (freq_output_valid === 1'b1) begin
          check("out_data", int'(freq_output_data), int'(exp_q[0]));
          if (freq_output_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_valid_spurious", int'(freq_output_valid), 0);
      end
    end
  end

  initial begin
    int r, k, base;
    reset             = 1'b0;
    pitch_input_valid = 1'b0;
    pitch_input_data  = '0;
    freq_output_ready = 1'b1;
    model_clear();
    #1;
    check("reset_valid", int'(freq_output_valid), 0);
    check("reset_data", int'(freq_output_data), 0);
    check("reset_ready", int'(pitch_input_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Lock, then a seventh identical bin stays silent.
    feed(100, 7, 1'b1);
    // Spike rejection.
    step(1'b1, 100, 1'b1); step(1'b1, 100, 1'b1); step(1'b1, 300, 1'b1);
    step(1'b1, 100, 1'b1); step(1'b1, 100, 1'b1);
    // Tolerance wobble, then a new note.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 101, 1'b1); step(1'b1, 100, 1'b1); step(1'b1, 101, 1'b1);
    end
    feed(200, 5, 1'b1);
    // Silence breaks the lock and allows re-reporting the same pitch.
    feed(100, 6, 1'b1);
    step(1'b1, 0, 1'b1);
    feed(100, 6, 1'b1);
    // Backpressure at the lock cycle; inputs offered while stalled are refused.
    step(1'b1, 0, 1'b1);
    feed(100, 5, 1'b1);
    feed(100, 1, 1'b0);
    feed(100, 3, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    // Reset mid-stall, then a full relock.
    step(1'b1, 0, 1'b1);
    feed(150, 6, 1'b0);
    step(1'b1, 150, 1'b0);
    do_reset();
    feed(150, 5, 1'b1);
    feed(150, 1, 1'b1);
    step(1'b0, 0, 1'b1);
    // Reset while locked and idle.
    do_reset();
    feed(150, 6, 1'b1);

    base = 100;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) base = int'($urandom_range(10, 900));
      if (r >= 3 && r < 6) k = int'($urandom_range(0, 3));
      else if (r >= 6 && r < 12) k = int'($urandom_range(4, 1023));
      else k = base + int'($urandom_range(0, 2)) - 1;
      step($urandom_range(0, 9) < 8, k, $urandom_range(0, 3) != 0);
      if (i == 300) do_reset();
    end

    repeat (4) step(1'b0, 0, 1'b1);
    check("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
